// File: rtl/inst_sram_axi_responder.sv
// Bridges the fetch-side SRAM-like request interface onto single-beat AXI reads.
// Holds at most one pending AR and tracks up to MAX_OUTSTANDING reads awaiting data.
module inst_sram_axi_responder #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  logic        ar_full;
  logic [31:0] ar_addr;
  logic [1:0]  cnt;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        ar_hs;
  logic        r_hs;
  logic        unused_inputs;

  assign unused_inputs = ^{inst_sram_we, inst_sram_wdata, rid, rresp, rlast};

  // A slot being released by this cycle's data_ok can be reused immediately,
  // which keeps the pipe full when the counter sits at its limit.
  assign accept = !reset && inst_sram_en && !ar_full &&
                  ((cnt < MAX_CNT) || data_ok_q);
  assign ar_hs  = ar_full && arready;
  assign r_hs   = rvalid && (cnt != 2'd0);

  assign addr_ok         = accept;
  assign arvalid         = ar_full && !reset;
  assign araddr          = ar_addr;
  assign rready          = (cnt != 2'd0) && !reset;
  assign data_ok         = data_ok_q && !reset;
  assign inst_sram_rdata = reset ? 32'h0 : rdata_q;

  assign arid    = AXI_ID;
  assign arlen   = 8'h00;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_full   <= 1'b0;
      ar_addr   <= 32'h0;
      cnt       <= 2'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      if (accept) begin
        ar_full <= 1'b1;
        ar_addr <= inst_sram_addr;
      end else if (ar_hs) begin
        ar_full <= 1'b0;
      end

      data_ok_q <= r_hs;
      if (r_hs) begin
        rdata_q <= rdata;
      end

      // Accept and retire in the same cycle cancel out.
      case ({accept, data_ok_q})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
